// File: rtl/calc2_req_scheduler.sv
// Round-robin request scheduler for the shared calc2 ALU: captures two-cycle requests per port,
// queues them per port and issues one at a time over a valid/ready link.
module calc2_req_scheduler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32
) (
    input  logic          c_clk,
    input  logic          reset,
    input  logic [3:0]    req1_cmd_in,
    input  logic [DW-1:0] req1_data_in,
    input  logic [1:0]    req1_tag_in,
    input  logic [3:0]    req2_cmd_in,
    input  logic [DW-1:0] req2_data_in,
    input  logic [1:0]    req2_tag_in,
    input  logic [3:0]    req3_cmd_in,
    input  logic [DW-1:0] req3_data_in,
    input  logic [1:0]    req3_tag_in,
    input  logic [3:0]    req4_cmd_in,
    input  logic [DW-1:0] req4_data_in,
    input  logic [1:0]    req4_tag_in,
    output logic          alu_valid,
    input  logic          alu_ready,
    output logic [3:0]    alu_cmd,
    output logic [DW-1:0] alu_op1,
    output logic [DW-1:0] alu_op2,
    output logic [1:0]    alu_port,
    output logic [1:0]    alu_tag,
    output logic [3:0]    port_full,
    output logic [3:0]    port_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 4 + 2 + 2 * DW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {StIdle, StOp2} cap_state_e;

    logic [3:0]    cmd_in  [4];
    logic [DW-1:0] data_in [4];
    logic [1:0]    tag_in  [4];

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;
    assign tag_in[0]  = req1_tag_in;
    assign tag_in[1]  = req2_tag_in;
    assign tag_in[2]  = req3_tag_in;
    assign tag_in[3]  = req4_tag_in;

    cap_state_e    state_q   [4];
    cap_state_e    state_d   [4];
    logic [3:0]    cap_cmd_q [4];
    logic [1:0]    cap_tag_q [4];
    logic [DW-1:0] cap_op1_q [4];
    logic [EW-1:0] mem_q     [4][DEPTH];
    logic [AW-1:0] wr_ptr_q  [4];
    logic [AW-1:0] rd_ptr_q  [4];
    logic [AW:0]   count_q   [4];
    logic [1:0]    rr_q;

    logic [3:0]    push_ok;
    logic [3:0]    pop;
    logic [3:0]    ovf_set;
    logic          load;
    logic          found;
    logic [1:0]    gnt;
    logic [1:0]    idx;
    logic [EW-1:0] head;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                StIdle:  if (cmd_in[k] != 4'd0) state_d[k] = StOp2;
                StOp2:   state_d[k] = StIdle;
                default: state_d[k] = StIdle;
            endcase
        end
    end

    // Grant scans upward from the RR pointer using pre-edge counts, so a push landing this
    // edge is not yet visible to the arbiter.
    always_comb begin
        found = 1'b0;
        gnt   = 2'd0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_q + 2'(i);
            if (!found && count_q[idx] != '0) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
        head = mem_q[gnt][rd_ptr_q[gnt]];
        load = !alu_valid || alu_ready;
        pop  = 4'd0;
        if (load && found) pop[gnt] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            port_full[k] = (count_q[k] == FULL_CNT);
            // A simultaneous pop frees the slot, so a push into a full queue still lands.
            push_ok[k]   = (state_q[k] == StOp2) && (!port_full[k] || pop[k]);
            ovf_set[k]   = (state_q[k] == StOp2) && port_full[k] && !pop[k];
        end
    end

    always_ff @(posedge c_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!reset && push_ok[k]) begin
                mem_q[k][wr_ptr_q[k]] <= {cap_cmd_q[k], cap_tag_q[k], cap_op1_q[k], data_in[k]};
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k]   <= StIdle;
                cap_cmd_q[k] <= '0;
                cap_tag_q[k] <= '0;
                cap_op1_q[k] <= '0;
                wr_ptr_q[k]  <= '0;
                rd_ptr_q[k]  <= '0;
                count_q[k]   <= '0;
            end
            rr_q      <= '0;
            port_ovf  <= '0;
            alu_valid <= 1'b0;
            alu_cmd   <= '0;
            alu_op1   <= '0;
            alu_op2   <= '0;
            alu_port  <= '0;
            alu_tag   <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                if (state_q[k] == StIdle && cmd_in[k] != 4'd0) begin
                    cap_cmd_q[k] <= cmd_in[k];
                    cap_tag_q[k] <= tag_in[k];
                    cap_op1_q[k] <= data_in[k];
                end
                if (push_ok[k]) wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
                if (pop[k])     rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
                if (push_ok[k] && !pop[k]) begin
                    count_q[k] <= count_q[k] + 1'b1;
                end else if (!push_ok[k] && pop[k]) begin
                    count_q[k] <= count_q[k] - 1'b1;
                end
                if (ovf_set[k]) port_ovf[k] <= 1'b1;
            end
            if (load) begin
                alu_valid <= found;
                if (found) begin
                    {alu_cmd, alu_tag, alu_op1, alu_op2} <= head;
                    alu_port <= gnt;
                    rr_q     <= gnt + 2'd1;
                end
            end
        end
    end

endmodule
